network_interface: RTL and testbench

- Local network interface (NI) between a processing element (PE) and its mesh router's local port.
- TX path: takes payload plus destination from the PE, builds a packet, buffers it, and injects it into the router with valid/ready.
- RX path: accepts packets the router ejects, checks the destination, buffers them, and presents them to the PE with valid/ready.
- Also keeps delivery counters and sticky error flags.

---
 rtl/network_interface_if.sv | 71 +++++++
 rtl/network_interface.sv | 155 +++++++++++++++
 tb/tb_network_interface.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/network_interface_if.sv
`default_nettype none
// ============================================================================
// pa_noc / network_interface_if
// Shared NoC constants plus the bundled PE/router signal set of the network
// interface. The slave modport is the NI's view; the master modport is the
// view of whatever drives the PE and router sides (PE, router, testbench).
//   TX : i_txPayload/i_txDestRow/i_txDestCol/i_txValid -> o_txReady
//        o_netPacket/o_netValid -> i_netReady
//   RX : i_netPacket/i_netValid -> o_netReady
//        o_rxPayload/o_rxSrcRow/o_rxSrcCol/o_rxValid -> i_rxReady
//   Status : i_clearErrors, o_rxOverflow, o_rxMisroute, o_txCount, o_rxCount
// Revision: 1.0 - initial release
// ============================================================================
package pa_noc;
  parameter int PACKET_WIDTH = 16;
endpackage

interface network_interface_if #(
  parameter int PACKET_WIDTH = pa_noc::PACKET_WIDTH
) ();
  localparam int PAYLOAD_WIDTH = PACKET_WIDTH - 8;

  logic [PAYLOAD_WIDTH-1:0] i_txPayload;
  logic [1:0]               i_txDestRow;
  logic [1:0]               i_txDestCol;
  logic                     i_txValid;
  logic                     o_txReady;
  logic [PACKET_WIDTH-1:0]  o_netPacket;
  logic                     o_netValid;
  logic                     i_netReady;
  logic [PACKET_WIDTH-1:0]  i_netPacket;
  logic                     i_netValid;
  logic                     o_netReady;
  logic [PAYLOAD_WIDTH-1:0] o_rxPayload;
  logic [1:0]               o_rxSrcRow;
  logic [1:0]               o_rxSrcCol;
  logic                     o_rxValid;
  logic                     i_rxReady;
  logic                     i_clearErrors;
  logic                     o_rxOverflow;
  logic                     o_rxMisroute;
  logic [15:0]              o_txCount;
  logic [15:0]              o_rxCount;

  modport slave (
    input  i_txPayload, i_txDestRow, i_txDestCol, i_txValid,
    output o_txReady,
    output o_netPacket, o_netValid,
    input  i_netReady,
    input  i_netPacket, i_netValid,
    output o_netReady,
    output o_rxPayload, o_rxSrcRow, o_rxSrcCol, o_rxValid,
    input  i_rxReady,
    input  i_clearErrors,
    output o_rxOverflow, o_rxMisroute, o_txCount, o_rxCount
  );

  modport master (
    output i_txPayload, i_txDestRow, i_txDestCol, i_txValid,
    input  o_txReady,
    input  o_netPacket, o_netValid,
    output i_netReady,
    output i_netPacket, i_netValid,
    input  o_netReady,
    input  o_rxPayload, o_rxSrcRow, o_rxSrcCol, o_rxValid,
    output i_rxReady,
    output i_clearErrors,
    input  o_rxOverflow, o_rxMisroute, o_txCount, o_rxCount
  );
endinterface
`default_nettype wire

// File: rtl/network_interface.sv
`default_nettype none
// ============================================================================
// network_interface
// Local NI between a processing element and its mesh router's local port.
// TX: forms {payload, src row, src col, dest row, dest col}, buffers it in a
//     FIFO and injects it through one registered output stage.
// RX: captures ejected packets into a show-ahead FIFO, flags misroutes and
//     overflows (sticky), and presents the head to the PE.
// Ports: i_clk, i_arst_n (async, active-low), ni (network_interface_if.slave)
// Revision: 1.0 - initial release
// ============================================================================
module network_interface #(
  parameter int GRID_WIDTH = 4,
  parameter int NI_ROW     = 0,
  parameter int NI_COL     = 0,
  parameter int TX_ADDR_W  = 2,
  parameter int RX_ADDR_W  = 2
) (
  input logic                 i_clk,
  input logic                 i_arst_n,
  network_interface_if.slave  ni
);
  localparam int PACKET_WIDTH = pa_noc::PACKET_WIDTH;
  localparam int COORD_W      = $clog2(GRID_WIDTH);
  localparam logic [COORD_W-1:0] NI_ROW_C = COORD_W'(NI_ROW);
  localparam logic [COORD_W-1:0] NI_COL_C = COORD_W'(NI_COL);
  localparam int TX_DEPTH = 2 ** TX_ADDR_W;
  localparam int RX_DEPTH = 2 ** RX_ADDR_W;
  localparam logic [TX_ADDR_W:0] TX_FULL_C = (TX_ADDR_W+1)'(TX_DEPTH);
  localparam logic [RX_ADDR_W:0] RX_FULL_C = (RX_ADDR_W+1)'(RX_DEPTH);
  localparam logic [RX_ADDR_W:0] RX_TWO_C  = (RX_ADDR_W+1)'(2);
  localparam logic               NET_READY_RST = (RX_DEPTH >= 2);

  // ---------------------------------------------------------------- TX path
  logic [PACKET_WIDTH-1:0] tx_mem_q [TX_DEPTH];
  logic [TX_ADDR_W-1:0]    tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TX_ADDR_W:0]      tx_cnt_q, tx_cnt_d;
  logic [PACKET_WIDTH-1:0] net_packet_q, net_packet_d;
  logic                    net_valid_q, net_valid_d;
  logic [15:0]             tx_count_q, tx_count_d;
  logic                    tx_full, tx_empty, tx_push, stage_load, stage_xfer;
  logic [PACKET_WIDTH-1:0] tx_pkt;

  // ---------------------------------------------------------------- RX path
  logic [PACKET_WIDTH-1:0] rx_mem_q [RX_DEPTH];
  logic [RX_ADDR_W-1:0]    rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RX_ADDR_W:0]      rx_cnt_q, rx_cnt_d;
  logic                    net_ready_q, net_ready_d;
  logic                    overflow_q, overflow_d, misroute_q, misroute_d;
  logic [15:0]             rx_count_q, rx_count_d;
  logic                    rx_full, rx_push, rx_pop, ovf_evt, misroute_evt;

  assign tx_pkt = {ni.i_txPayload, NI_ROW_C, NI_COL_C, ni.i_txDestRow, ni.i_txDestCol};

  always_comb begin
    tx_full    = (tx_cnt_q == TX_FULL_C);
    tx_empty   = (tx_cnt_q == '0);
    tx_push    = ni.i_txValid && !tx_full;
    stage_xfer = net_valid_q && ni.i_netReady;
    // Refill whenever the stage is empty or is being emptied this cycle.
    stage_load = !tx_empty && (!net_valid_q || ni.i_netReady);

    tx_wr_d  = tx_push    ? tx_wr_q + 1'b1 : tx_wr_q;
    tx_rd_d  = stage_load ? tx_rd_q + 1'b1 : tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !stage_load)      tx_cnt_d = tx_cnt_q + (TX_ADDR_W+1)'(1);
    else if (!tx_push && stage_load) tx_cnt_d = tx_cnt_q - (TX_ADDR_W+1)'(1);

    net_valid_d  = net_valid_q;
    net_packet_d = net_packet_q;
    if (stage_load) begin
      net_valid_d  = 1'b1;
      net_packet_d = tx_mem_q[tx_rd_q];
    end else if (stage_xfer) begin
      net_valid_d  = 1'b0;
      net_packet_d = '0;
    end
    tx_count_d = stage_xfer ? tx_count_q + 16'd1 : tx_count_q;
  end

  always_comb begin
    rx_full = (rx_cnt_q == RX_FULL_C);
    rx_pop  = (rx_cnt_q != '0) && ni.i_rxReady;
    // A pop in the same cycle frees the slot the incoming packet needs.
    rx_push      = ni.i_netValid && (!rx_full || rx_pop);
    ovf_evt      = ni.i_netValid && rx_full && !rx_pop;
    misroute_evt = ni.i_netValid &&
                   ((ni.i_netPacket[3:2] != NI_ROW_C) || (ni.i_netPacket[1:0] != NI_COL_C));

    rx_wr_d  = rx_push ? rx_wr_q + 1'b1 : rx_wr_q;
    rx_rd_d  = rx_pop  ? rx_rd_q + 1'b1 : rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + (RX_ADDR_W+1)'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - (RX_ADDR_W+1)'(1);

    // The router commits one cycle ahead of its pulse, so advertise ready
    // only while two slots remain after this cycle's traffic.
    net_ready_d = ((RX_FULL_C - rx_cnt_d) >= RX_TWO_C);
    overflow_d  = ovf_evt      || (overflow_q && !ni.i_clearErrors);
    misroute_d  = misroute_evt || (misroute_q && !ni.i_clearErrors);
    rx_count_d  = rx_pop ? rx_count_q + 16'd1 : rx_count_q;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      tx_wr_q      <= '0;
      tx_rd_q      <= '0;
      tx_cnt_q     <= '0;
      net_packet_q <= '0;
      net_valid_q  <= 1'b0;
      tx_count_q   <= '0;
      rx_wr_q      <= '0;
      rx_rd_q      <= '0;
      rx_cnt_q     <= '0;
      net_ready_q  <= NET_READY_RST;
      overflow_q   <= 1'b0;
      misroute_q   <= 1'b0;
      rx_count_q   <= '0;
    end else begin
      tx_wr_q      <= tx_wr_d;
      tx_rd_q      <= tx_rd_d;
      tx_cnt_q     <= tx_cnt_d;
      net_packet_q <= net_packet_d;
      net_valid_q  <= net_valid_d;
      tx_count_q   <= tx_count_d;
      rx_wr_q      <= rx_wr_d;
      rx_rd_q      <= rx_rd_d;
      rx_cnt_q     <= rx_cnt_d;
      net_ready_q  <= net_ready_d;
      overflow_q   <= overflow_d;
      misroute_q   <= misroute_d;
      rx_count_q   <= rx_count_d;
    end
  end

  // Storage arrays need no reset: occupancy lives in the pointers/counts.
  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= tx_pkt;
    if (rx_push) rx_mem_q[rx_wr_q] <= ni.i_netPacket;
  end

  assign ni.o_txReady    = !tx_full;
  assign ni.o_netPacket  = net_packet_q;
  assign ni.o_netValid   = net_valid_q;
  assign ni.o_txCount    = tx_count_q;
  assign ni.o_netReady   = net_ready_q;
  assign ni.o_rxValid    = (rx_cnt_q != '0);
  assign ni.o_rxPayload  = rx_mem_q[rx_rd_q][PACKET_WIDTH-1:8];
  assign ni.o_rxSrcRow   = rx_mem_q[rx_rd_q][7:6];
  assign ni.o_rxSrcCol   = rx_mem_q[rx_rd_q][5:4];
  assign ni.o_rxOverflow = overflow_q;
  assign ni.o_rxMisroute = misroute_q;
  assign ni.o_rxCount    = rx_count_q;
endmodule
`default_nettype wire

// File: tb/tb_network_interface.sv
`default_nettype none
// ============================================================================
// tb_network_interface
// Directed self-checking bench for network_interface at node (1,2) with
// 4-deep TX and RX FIFOs: reset, TX latency/format, TX backpressure, RX
// ordering/readiness, sticky error flags, counter wrap, mid-run reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_network_interface;
  localparam int PW = pa_noc::PACKET_WIDTH;
  localparam logic [1:0] ROW = 2'd1;
  localparam logic [1:0] COL = 2'd2;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  network_interface_if #(.PACKET_WIDTH(PW)) bus ();

  network_interface #(
    .GRID_WIDTH(4), .NI_ROW(1), .NI_COL(2), .TX_ADDR_W(2), .RX_ADDR_W(2)
  ) dut (
    .i_clk    (clk),
    .i_arst_n (arst_n),
    .ni       (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [PW-9:0] pl, input logic [1:0] sr,
                                       input logic [1:0] sc, input logic [1:0] dr,
                                       input logic [1:0] dc);
    return {pl, sr, sc, dr, dc};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_txPayload = '0; bus.i_txDestRow = '0; bus.i_txDestCol = '0;
    bus.i_txValid = 1'b0; bus.i_netReady = 1'b0; bus.i_netPacket = '0;
    bus.i_netValid = 1'b0; bus.i_rxReady = 1'b0; bus.i_clearErrors = 1'b0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);

    // Reset / idle state
    check("rst_txReady",  32'(bus.o_txReady), 32'd1);
    check("rst_netReady", 32'(bus.o_netReady), 32'd1);
    check("rst_netValid", 32'(bus.o_netValid), 32'd0);
    check("rst_rxValid",  32'(bus.o_rxValid), 32'd0);
    check("rst_txCount",  32'(bus.o_txCount), 32'd0);
    check("rst_rxCount",  32'(bus.o_rxCount), 32'd0);
    check("rst_flags",    32'({bus.o_rxOverflow, bus.o_rxMisroute}), 32'd0);

    // Single packet: payload 0x5A to (3,0) from (1,2) -> 0x5A_6C
    bus.i_txPayload = 8'h5A; bus.i_txDestRow = 2'd3; bus.i_txDestCol = 2'd0;
    bus.i_txValid = 1'b1; bus.i_netReady = 1'b1;
    @(negedge clk);
    bus.i_txValid = 1'b0;
    check("tx_lat1_valid", 32'(bus.o_netValid), 32'd0);
    @(negedge clk);
    check("tx_lat2_valid", 32'(bus.o_netValid), 32'd1);
    check("tx_packet",     32'(bus.o_netPacket), 32'h5A6C);
    @(negedge clk);
    check("tx_one_cycle",  32'(bus.o_netValid), 32'd0);
    check("tx_pkt_zero",   32'(bus.o_netPacket), 32'd0);
    check("tx_count1",     32'(bus.o_txCount), 32'd1);

    // Backpressure: 6 attempts, 5 accepted (stage + 4 FIFO entries)
    bus.i_netReady = 1'b0; bus.i_txDestRow = 2'd0; bus.i_txDestCol = 2'd1;
    for (int i = 0; i < 6; i++) begin
      check("bp_txReady", 32'(bus.o_txReady), (i < 5) ? 32'd1 : 32'd0);
      bus.i_txPayload = 8'(8'h10 + i);
      bus.i_txValid = 1'b1;
      @(negedge clk);
    end
    bus.i_txValid = 1'b0;
    check("bp_full",     32'(bus.o_txReady), 32'd0);
    check("bp_hold_vld", 32'(bus.o_netValid), 32'd1);
    bus.i_netReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_drain_vld", 32'(bus.o_netValid), 32'd1);
      check("bp_drain_pl",  32'(bus.o_netPacket[PW-1:8]), 32'(8'h10 + k));
      @(negedge clk);
    end
    check("bp_empty",   32'(bus.o_netValid), 32'd0);
    check("bp_txCount", 32'(bus.o_txCount), 32'd6);
    check("bp_txReady", 32'(bus.o_txReady), 32'd1);

    // RX: three packets for (1,2), PE stalled
    bus.i_rxReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rx_netReady_pre", 32'(bus.o_netReady), 32'd1);
      bus.i_netPacket = mk(8'(8'hA0 + k), 2'(k), 2'(3 - k), ROW, COL);
      bus.i_netValid = 1'b1;
      @(negedge clk);
    end
    bus.i_netValid = 1'b0;
    check("rx_netReady_low", 32'(bus.o_netReady), 32'd0);
    check("rx_valid",        32'(bus.o_rxValid), 32'd1);
    bus.i_rxReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("rx_drain_vld", 32'(bus.o_rxValid), 32'd1);
      check("rx_drain_pl",  32'(bus.o_rxPayload), 32'(8'hA0 + k));
      check("rx_src_row",   32'(bus.o_rxSrcRow), 32'(k));
      check("rx_src_col",   32'(bus.o_rxSrcCol), 32'(3 - k));
      @(negedge clk);
    end
    bus.i_rxReady = 1'b0;
    check("rx_empty",    32'(bus.o_rxValid), 32'd0);
    check("rx_count3",   32'(bus.o_rxCount), 32'd3);
    check("rx_netReady", 32'(bus.o_netReady), 32'd1);
    check("rx_noflags",  32'({bus.o_rxOverflow, bus.o_rxMisroute}), 32'd0);

    // Misroute: dest (0,0) is foreign but still stored
    bus.i_netPacket = mk(8'hB0, 2'd3, 2'd0, 2'd0, 2'd0);
    bus.i_netValid = 1'b1;
    @(negedge clk);
    bus.i_netValid = 1'b0;
    check("mis_set",   32'(bus.o_rxMisroute), 32'd1);
    check("mis_noovf", 32'(bus.o_rxOverflow), 32'd0);
    check("mis_kept",  32'(bus.o_rxValid), 32'd1);

    // Fill to 4, then one more while full -> overflow
    for (int k = 0; k < 3; k++) begin
      bus.i_netPacket = mk(8'(8'hC0 + k), 2'd0, 2'd0, ROW, COL);
      bus.i_netValid = 1'b1;
      @(negedge clk);
    end
    bus.i_netPacket = mk(8'hD0, 2'd0, 2'd0, ROW, COL);
    @(negedge clk);
    bus.i_netValid = 1'b0;
    check("ovf_set",      32'(bus.o_rxOverflow), 32'd1);
    check("ovf_netReady", 32'(bus.o_netReady), 32'd0);

    // Clear coinciding with new events: set wins
    bus.i_clearErrors = 1'b1;
    bus.i_netPacket = mk(8'hE0, 2'd0, 2'd0, 2'd3, 2'd3);
    bus.i_netValid = 1'b1;
    @(negedge clk);
    bus.i_clearErrors = 1'b0; bus.i_netValid = 1'b0;
    check("clr_vs_ovf", 32'(bus.o_rxOverflow), 32'd1);
    check("clr_vs_mis", 32'(bus.o_rxMisroute), 32'd1);
    bus.i_clearErrors = 1'b1;
    @(negedge clk);
    bus.i_clearErrors = 1'b0;
    check("clr_ovf", 32'(bus.o_rxOverflow), 32'd0);
    check("clr_mis", 32'(bus.o_rxMisroute), 32'd0);

    // Occupancy stayed at 4: B0, C0, C1, C2
    bus.i_rxReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("occ_vld", 32'(bus.o_rxValid), 32'd1);
      check("occ_pl",  32'(bus.o_rxPayload), (k == 0) ? 32'hB0 : 32'(8'hC0 + k - 1));
      @(negedge clk);
    end
    bus.i_rxReady = 1'b0;
    check("occ_empty",  32'(bus.o_rxValid), 32'd0);
    check("occ_rxCount", 32'(bus.o_rxCount), 32'd7);

    // Counter wrap: stream 65529 packets (6 -> 0xFFFF), then one more
    bus.i_netReady = 1'b1; bus.i_txValid = 1'b1;
    repeat (65529) @(negedge clk);
    bus.i_txValid = 1'b0;
    repeat (4) @(negedge clk);
    check("wrap_ffff",  32'(bus.o_txCount), 32'hFFFF);
    check("wrap_idle",  32'(bus.o_netValid), 32'd0);
    bus.i_txValid = 1'b1;
    @(negedge clk);
    bus.i_txValid = 1'b0;
    repeat (3) @(negedge clk);
    check("wrap_zero",  32'(bus.o_txCount), 32'd0);

    // Reset mid-operation discards buffered packets
    bus.i_netReady = 1'b0;
    bus.i_netPacket = mk(8'h77, 2'd0, 2'd0, ROW, COL);
    bus.i_netValid = 1'b1; bus.i_txValid = 1'b1;
    @(negedge clk);
    bus.i_netValid = 1'b0; bus.i_txValid = 1'b0;
    check("mid_rx_held", 32'(bus.o_rxValid), 32'd1);
    arst_n = 1'b0;
    #1;
    check("mid_rx_gone", 32'(bus.o_rxValid), 32'd0);
    @(negedge clk);
    arst_n = 1'b1; bus.i_netReady = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_tx_gone", 32'(bus.o_netValid), 32'd0);
    check("mid_txCount", 32'(bus.o_txCount), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
